// File: rtl/top.sv
// Serial configuration loader: shifts {STAT_INIT, DYN_INIT} MSB-first through a
// 104-bit chain, then latches the chain into the dynamic/static outputs once.
module top #(
    parameter logic [15:0] DYN_INIT  = 16'hA5C3,
    parameter logic [87:0] STAT_INIT = 88'h0123456789ABCDEF012345
) (
    input  logic         CLK,
    input  logic         RST_N,
    output logic [15:0]  DYNLATCH,
    output logic [87:0]  STATLATCH,
    output logic         ENFIN,
    output logic         generated_signal
);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

    localparam int unsigned CHAIN_W = 104;

    state_t               state, state_nxt;
    logic [CHAIN_W-1:0]   src;
    logic [CHAIN_W-1:0]   chain;
    logic [6:0]           cnt;

    always_comb begin
        state_nxt        = state;
        generated_signal = 1'b0;
        case (state)
            IDLE:  state_nxt = SHIFT;
            SHIFT: begin
                generated_signal = src[CHAIN_W-1];
                if (cnt == 7'd103) state_nxt = LATCH;
            end
            LATCH: state_nxt = DONE;
            DONE:  state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // RST_N is active-high despite its name; it also reloads the source word.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            state     <= IDLE;
            src       <= {STAT_INIT, DYN_INIT};
            chain     <= '0;
            cnt       <= '0;
            DYNLATCH  <= '0;
            STATLATCH <= '0;
            ENFIN     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == SHIFT) begin
                chain <= {chain[CHAIN_W-2:0], generated_signal};
                src   <= {src[CHAIN_W-2:0], 1'b0};
                cnt   <= cnt + 7'd1;
            end
            // Outputs only ever see the completed chain, never a partial shift.
            if (state == LATCH) begin
                DYNLATCH  <= chain[15:0];
                STATLATCH <= chain[CHAIN_W-1:16];
                ENFIN     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// Bench for the serial configuration loader: default and overridden parameter
// instances share clock and reset and are checked against hand-computed values.
module tb_top;

    localparam logic [15:0]  DYN_A  = 16'hA5C3;
    localparam logic [87:0]  STAT_A = 88'h0123456789ABCDEF012345;
    localparam logic [15:0]  DYN_B  = 16'hFFFF;
    localparam logic [87:0]  STAT_B = 88'h0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  dyn_a, dyn_b;
    logic [87:0]  stat_a, stat_b;
    logic         enfin_a, enfin_b;
    logic         gen_a, gen_b;

    int checks = 0;
    int errors = 0;

    top dut_a (
        .CLK(clk), .RST_N(rst), .DYNLATCH(dyn_a), .STATLATCH(stat_a),
        .ENFIN(enfin_a), .generated_signal(gen_a)
    );

    top #(.DYN_INIT(DYN_B), .STAT_INIT(STAT_B)) dut_b (
        .CLK(clk), .RST_N(rst), .DYNLATCH(dyn_b), .STATLATCH(stat_b),
        .ENFIN(enfin_b), .generated_signal(gen_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        int           edges;
        logic         exp_enfin;
        logic [15:0]  exp_dyn_a;
        logic [87:0]  exp_stat_a;
        logic         exp_gen_a;
        logic [15:0]  exp_dyn_b;
        logic [87:0]  exp_stat_b;
        logic         exp_gen_b;
    } vec_t;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " enfin_a"}, 104'(enfin_a), 104'(v.exp_enfin));
        chk({tag, " dyn_a"},   104'(dyn_a),   104'(v.exp_dyn_a));
        chk({tag, " stat_a"},  104'(stat_a),  104'(v.exp_stat_a));
        chk({tag, " gen_a"},   104'(gen_a),   104'(v.exp_gen_a));
        chk({tag, " enfin_b"}, 104'(enfin_b), 104'(v.exp_enfin));
        chk({tag, " dyn_b"},   104'(dyn_b),   104'(v.exp_dyn_b));
        chk({tag, " stat_b"},  104'(stat_b),  104'(v.exp_stat_b));
        chk({tag, " gen_b"},   104'(gen_b),   104'(v.exp_gen_b));
    endtask

    initial begin
        vec_t         tbl [8];
        logic [103:0] stream_a, stream_b;
        int           n;

        // rst, edges, enfin, dyn_a, stat_a, gen_a, dyn_b, stat_b, gen_b
        tbl[0] = '{1'b1,   2, 1'b0, 16'h0, 88'h0, 1'b0, 16'h0, 88'h0, 1'b0}; // reset
        tbl[1] = '{1'b0,   1, 1'b0, 16'h0, 88'h0, 1'b0, 16'h0, 88'h0, 1'b0}; // first SHIFT bit
        tbl[2] = '{1'b0, 103, 1'b0, 16'h0, 88'h0, 1'b1, 16'h0, 88'h0, 1'b1}; // last SHIFT bit
        tbl[3] = '{1'b0,   1, 1'b0, 16'h0, 88'h0, 1'b0, 16'h0, 88'h0, 1'b0}; // LATCH
        tbl[4] = '{1'b0,   1, 1'b1, DYN_A, STAT_A, 1'b0, DYN_B, STAT_B, 1'b0}; // DONE
        tbl[5] = '{1'b0,  10, 1'b1, DYN_A, STAT_A, 1'b0, DYN_B, STAT_B, 1'b0}; // held
        tbl[6] = '{1'b1,   1, 1'b0, 16'h0, 88'h0, 1'b0, 16'h0, 88'h0, 1'b0}; // reset in DONE
        tbl[7] = '{1'b0, 106, 1'b1, DYN_A, STAT_A, 1'b0, DYN_B, STAT_B, 1'b0}; // rerun

        for (int i = 0; i < 8; i++) begin
            rst = tbl[i].rst;
            tick(tbl[i].edges);
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Full run: capture the serial stream and watch for partial latch values.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        stream_a = '0;
        stream_b = '0;
        for (int k = 1; k <= 106; k++) begin
            tick(1);
            if (k <= 104) begin
                stream_a[104-k] = gen_a;
                stream_b[104-k] = gen_b;
            end
            if (k < 106) begin
                chk($sformatf("early enfin_a e%0d", k), 104'(enfin_a), 104'(0));
                chk($sformatf("early dyn_a e%0d", k), 104'(dyn_a), 104'(0));
                chk($sformatf("early stat_a e%0d", k), 104'(stat_a), 104'(0));
                chk($sformatf("early stat_b e%0d", k), 104'(stat_b), 104'(0));
                chk($sformatf("early dyn_b e%0d", k), 104'(dyn_b), 104'(0));
            end
        end
        chk("stream_a", stream_a, {STAT_A, DYN_A});
        chk("stream_b", stream_b, {STAT_B, DYN_B});
        chk("enfin_a at 106", 104'(enfin_a), 104'(1));

        // Single-cycle reset at shift cycle 50, then time the restart.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(51);
        chk("mid enfin before abort", 104'(enfin_a), 104'(0));
        rst = 1'b1;
        tick(1);
        chk("abort dyn_a", 104'(dyn_a), 104'(0));
        chk("abort stat_a", 104'(stat_a), 104'(0));
        chk("abort enfin_a", 104'(enfin_a), 104'(0));
        chk("abort gen_a", 104'(gen_a), 104'(0));
        rst = 1'b0;
        n = 0;
        for (int e = 1; e <= 200; e++) begin
            tick(1);
            if (enfin_a) begin
                n = e;
                break;
            end
        end
        chk("restart enfin edge", 104'(n), 104'(106));
        chk("restart dyn_a", 104'(dyn_a), 104'(DYN_A));
        chk("restart stat_a", 104'(stat_a), 104'(STAT_A));
        chk("restart dyn_b", 104'(dyn_b), 104'(DYN_B));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
